regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port integer register file with an integrated per-register scoreboard, for the pipelined core. It supersedes the single-write-port, two-read-port register file. It adds:
- configurable width, depth and port counts;
- same-cycle write-to-read bypass;
- busy/owner-tag tracking, so decode can detect RAW hazards and only the youngest in-flight writer releases a register.

## Interface
Parameters:
- DW, 64: data width of each register.
- NREG, 32: number of registers (power of two); AW = $clog2(NREG).
- NRD, 2: number of read ports.
- NWR, 2: number of writeback ports.
- TW, 4: width of the issue/writeback owner tag.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- rd_addr  in  NRD×AW  read port addresses.
- rd_data  out  NRD×DW  read data, combinational, with bypass.
- rd_busy  out  NRD  register has an outstanding writer.
- iss_valid  in  1  issue: mark a destination busy.
- iss_addr  in  AW  destination register.
- iss_tag  in  TW  owner tag of the issuing instruction.
- wb_valid  in  NWR  writeback port valid.
- wb_addr  in  NWR×AW  writeback register.
- wb_data  in  NWR×DW  writeback data.
- wb_tag  in  NWR×TW  tag of the writing instruction.
- flush  in  1  clear every busy bit (pipeline squash).
- busy_count  out  AW+1  number of registers currently busy, registered.

## Operation
**Register 0**
- Reads 0.
- Never busy.
- Writes to it and issues to it are ignored.

**Write**
- When wb_valid[i] is set and wb_addr[i] != 0, wb_data[i] is stored at the clock edge.
- If two ports target the same register in one cycle, the higher index wins.

**Read bypass**
- If rd_addr[j] matches any valid, nonzero wb_addr this cycle, rd_data[j] returns that wb_data (highest-index match wins).
- Otherwise rd_data[j] returns the stored value.

**Scoreboard state**
- Each register holds busy[r] and owner[r].

**Issue**
- When iss_valid is set and iss_addr != 0: at the edge, busy ← 1 and owner ← iss_tag.
- A reissue to an already-busy register overwrites owner (WAW).

**Release**
- A valid writeback clears busy[r] only if wb_tag == owner[r].
- Data is written regardless of whether the tag matches.

**rd_busy[j]**
- Equals busy[rd_addr[j]], except it reads 0 when a same-cycle writeback releases that register (tag match).
- A same-cycle issue is not reflected until the next cycle.

**Priority within one cycle**
- flush > issue > release. Issue and release to the same register leave it busy, with the new owner.

**Flush**
- Clears all busy bits at the edge.
- An issue in the same cycle is dropped.
- Writebacks in the same cycle still write data.
- Owner tags are left unchanged.

**busy_count**
- Population count of the busy vector, registered: it equals the vector as of the previous edge.

## Timing
- Reset asserted, asynchronously: all registers, busy bits, owner tags and busy_count become 0. rd_data reads 0 and rd_busy reads 0 for every address.
- Reset deassertion is sampled synchronously; the first update occurs at the first edge after release.
- A reset during an outstanding issue discards all busy state; late writebacks after reset write data but clear nothing, since there is no busy state to clear.
- Read latency: 0 cycles (combinational from rd_addr and wb_*).
- Write-to-read: same cycle via bypass; from the array on the cycle after the edge.
- Issue to rd_busy: 1 cycle.
- Release to rd_busy: same cycle (bypassed).
- busy_count lags the busy vector by 1 edge.

## Structure
**Package regfile_pkg**
- Default DW/NREG/TW.
- Typedefs reg_addr_t, reg_data_t, reg_tag_t.
- Constant ZERO_REG = 0.

**Sub-module regfile_scoreboard**
- Holds busy[], owner[], the issue/release/flush priority logic and the busy_count popcount.
- Exports the busy vector and a per-port release-match vector.

**Top level**
- Holds the data array, the write-port merge and the read bypass muxes.

## Test plan
1. Reset, then write x0 ← 0xDEAD with tag 3, and read x0 → rd_data=0, rd_busy=0; issue x0 → busy_count stays 0.
2. Bypass: wb[0] writes x5=0x1234 and rd_addr[0]=5 in the same cycle → rd_data[0]=0x1234 that cycle, and rd_data[0]=0x1234 from the array the next cycle.
3. Dual-port collision: wb[0] writes x7=0xAA and wb[1] writes x7=0xBB in the same cycle → rd_data=0xBB, both bypassed and stored.
4. Scoreboard WAW:
   - issue x9 tag 1, then issue x9 tag 2;
   - wb x9 tag 1 = 0x11 → data stored, rd_busy stays 1;
   - wb tag 2 = 0x22 → rd_busy=0 the same cycle, busy_count=0 the next cycle.
5. Issue to x4 (tag 5) with a same-cycle release (tag 5), then flush with issue x6 in the same cycle → x4 busy with owner 5, then all busy bits clear, x6 not busy, busy_count=0.
6. Issue x3, x8 and x12, then assert reset mid-stream → all outputs 0 asynchronously; after release, wb x3 tag 0 = 0x55 → x3 reads 0x55, rd_busy=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizing defaults, register-file typedefs and the hard-wired zero register index.
// No logic; imported by the register file and its scoreboard.
package regfile_pkg;
    localparam int DW_DEF   = 64;
    localparam int NREG_DEF = 32;
    localparam int TW_DEF   = 4;
    localparam int AW_DEF   = $clog2(NREG_DEF);
    localparam int ZERO_REG = 0;

    typedef logic [AW_DEF-1:0] reg_addr_t;
    typedef logic [DW_DEF-1:0] reg_data_t;
    typedef logic [TW_DEF-1:0] reg_tag_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy/owner tracking with flush > issue > release priority, plus registered busy popcount.
// Latency: busy updates at the edge, rel_match is combinational; backpressure: none, always accepts.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREG = NREG_DEF,
    parameter  int NWR  = 2,
    parameter  int TW   = TW_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     iss_valid,
    input  logic [AW-1:0]            iss_addr,
    input  logic [TW-1:0]            iss_tag,
    input  logic [NWR-1:0]           wb_valid,
    input  logic [NWR-1:0][AW-1:0]   wb_addr,
    input  logic [NWR-1:0][TW-1:0]   wb_tag,
    input  logic                     flush,
    output logic [NREG-1:0]          busy,
    output logic [NWR-1:0]           rel_match,
    output logic [AW:0]              busy_count
);
    localparam int CW = AW + 1;

    logic [TW-1:0]   owner [NREG];
    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     count_nxt;
    logic            iss_take;

    assign iss_take = iss_valid && !flush && (iss_addr != AW'(ZERO_REG));

    // A tag match against a non-busy register is harmless: there is nothing to clear.
    always_comb begin
        rel_match = '0;
        for (int i = 0; i < NWR; i++) begin
            rel_match[i] = wb_valid[i] && (wb_addr[i] != AW'(ZERO_REG)) &&
                           (wb_tag[i] == owner[wb_addr[i]]);
        end
    end

    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < NWR; i++) begin
            if (rel_match[i]) busy_nxt[wb_addr[i]] = 1'b0;
        end
        if (iss_take) busy_nxt[iss_addr] = 1'b1;
        if (flush) busy_nxt = '0;
        busy_nxt[ZERO_REG] = 1'b0;

        // Counting the next vector makes busy_count reflect the state established at the last edge.
        count_nxt = '0;
        for (int r = 0; r < NREG; r++) begin
            count_nxt = count_nxt + CW'(busy_nxt[r]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= '0;
            busy_count <= '0;
            for (int r = 0; r < NREG; r++) owner[r] <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= count_nxt;
            if (iss_take) owner[iss_addr] <= iss_tag;
        end
    end
endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with same-cycle write-to-read bypass and RAW scoreboard.
// Latency: reads 0 cycles (bypassed), writes at the edge; backpressure: none, every port always accepts.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int DW   = DW_DEF,
    parameter  int NREG = NREG_DEF,
    parameter  int NRD  = 2,
    parameter  int NWR  = 2,
    parameter  int TW   = TW_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    output logic [NRD-1:0][DW-1:0]   rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic                     iss_valid,
    input  logic [AW-1:0]            iss_addr,
    input  logic [TW-1:0]            iss_tag,
    input  logic [NWR-1:0]           wb_valid,
    input  logic [NWR-1:0][AW-1:0]   wb_addr,
    input  logic [NWR-1:0][DW-1:0]   wb_data,
    input  logic [NWR-1:0][TW-1:0]   wb_tag,
    input  logic                     flush,
    output logic [AW:0]              busy_count
);
    logic [DW-1:0]   mem [NREG];
    logic [NREG-1:0] busy;
    logic [NWR-1:0]  rel_match;
    logic [NWR-1:0]  wb_we;

    regfile_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR),
        .TW   (TW)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .iss_valid  (iss_valid),
        .iss_addr   (iss_addr),
        .iss_tag    (iss_tag),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_tag     (wb_tag),
        .flush      (flush),
        .busy       (busy),
        .rel_match  (rel_match),
        .busy_count (busy_count)
    );

    always_comb begin
        wb_we = '0;
        for (int i = 0; i < NWR; i++) begin
            wb_we[i] = wb_valid[i] && (wb_addr[i] != AW'(ZERO_REG));
        end
    end

    // Ascending port order: the highest-index writer to a register lands last and wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) mem[r] <= '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (wb_we[i]) mem[wb_addr[i]] <= wb_data[i];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int j = 0; j < NRD; j++) begin
            if (rd_addr[j] != AW'(ZERO_REG)) begin
                rd_data[j] = mem[rd_addr[j]];
                rd_busy[j] = busy[rd_addr[j]];
                for (int i = 0; i < NWR; i++) begin
                    if (wb_we[i] && (wb_addr[i] == rd_addr[j])) begin
                        rd_data[j] = wb_data[i];
                        if (rel_match[i]) rd_busy[j] = 1'b0;
                    end
                end
            end
            // Bypassed writeback data must not leak out while reset is held.
            if (!reset) begin
                rd_data[j] = '0;
                rd_busy[j] = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: spec-level model compared every cycle, plus literal spot checks.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int DW = 64, NREG = 32, NRD = 2, NWR = 2, TW = 4, AW = 5;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [NRD-1:0][AW-1:0] rd_addr = '0;
    logic [NRD-1:0][DW-1:0] rd_data;
    logic [NRD-1:0]         rd_busy;
    logic                   iss_valid = 1'b0;
    logic [AW-1:0]          iss_addr = '0;
    logic [TW-1:0]          iss_tag = '0;
    logic [NWR-1:0]         wb_valid = '0;
    logic [NWR-1:0][AW-1:0] wb_addr = '0;
    logic [NWR-1:0][DW-1:0] wb_data = '0;
    logic [NWR-1:0][TW-1:0] wb_tag = '0;
    logic                   flush = 1'b0;
    logic [AW:0]            busy_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    reg_data_t m_data  [NREG];
    bit        m_busy  [NREG];
    reg_tag_t  m_owner [NREG];
    bit        m_rel   [NREG];

    always #5 clk = ~clk;

    regfile_sb #(.DW(DW), .NREG(NREG), .NRD(NRD), .NWR(NWR), .TW(TW)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .iss_valid  (iss_valid),
        .iss_addr   (iss_addr),
        .iss_tag    (iss_tag),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_tag     (wb_tag),
        .flush      (flush),
        .busy_count (busy_count)
    );

    // Architectural model: data array, busy set and owner table updated by the rules of one edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                m_data[r] = '0; m_busy[r] = 1'b0; m_owner[r] = '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) m_rel[r] = 1'b0;
            for (int i = 0; i < NWR; i++) begin
                if (wb_valid[i] && wb_addr[i] != 0) begin
                    if (wb_tag[i] == m_owner[wb_addr[i]]) m_rel[wb_addr[i]] = 1'b1;
                    m_data[wb_addr[i]] = wb_data[i];
                end
            end
            for (int r = 0; r < NREG; r++) if (m_rel[r]) m_busy[r] = 1'b0;
            if (flush) begin
                for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
            end else if (iss_valid && iss_addr != 0) begin
                m_busy[iss_addr]  = 1'b1;
                m_owner[iss_addr] = iss_tag;
            end
        end
    end

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (!reset || a == 0) return '0;
        v = m_data[a];
        for (int i = 0; i < NWR; i++) if (wb_valid[i] && wb_addr[i] == a) v = wb_data[i];
        return v;
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        logic b;
        if (!reset || a == 0) return 1'b0;
        b = m_busy[a];
        for (int i = 0; i < NWR; i++)
            if (wb_valid[i] && wb_addr[i] == a && wb_tag[i] == m_owner[a]) b = 1'b0;
        return b;
    endfunction

    function automatic int m_cnt();
        int n = 0;
        for (int r = 0; r < NREG; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int j = 0; j < NRD; j++) begin
                check($sformatf("model rd_data[%0d]", j), rd_data[j], exp_data(rd_addr[j]));
                check($sformatf("model rd_busy[%0d]", j), 64'(rd_busy[j]), 64'(exp_busy(rd_addr[j])));
            end
            check("model busy_count", 64'(busy_count), 64'(m_cnt()));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        wb_valid  = '0;
        flush     = 1'b0;
    endtask

    task automatic wb(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [TW-1:0] t);
        wb_valid[i] = 1'b1; wb_addr[i] = a; wb_data[i] = d; wb_tag[i] = t;
    endtask

    task automatic iss(input logic [AW-1:0] a, input logic [TW-1:0] t);
        iss_valid = 1'b1; iss_addr = a; iss_tag = t;
    endtask

    initial begin
        repeat (2) cyc();
        chk_en = 1'b1;
        rd_addr[0] = 5'd7;
        #2;
        check("reset rd_data0", rd_data[0], 64'h0);
        check("reset busy_count", 64'(busy_count), 64'h0);
        reset = 1'b1;

        // Register 0 ignores writes and issues
        cyc(); wb(0, 5'd0, 64'hDEAD, 4'd3); iss(5'd0, 4'd3); rd_addr[0] = 5'd0;
        #2; check("x0 rd_data", rd_data[0], 64'h0); check("x0 rd_busy", 64'(rd_busy[0]), 64'h0);
        cyc(); idle();
        #2; check("x0 busy_count", 64'(busy_count), 64'h0);

        // Same-cycle bypass then stored value
        cyc(); wb(0, 5'd5, 64'h1234, 4'd0); rd_addr[0] = 5'd5;
        #2; check("bypass x5", rd_data[0], 64'h1234);
        cyc(); idle();
        #2; check("stored x5", rd_data[0], 64'h1234);

        // Two writeback ports hit x7: port 1 wins
        cyc(); wb(0, 5'd7, 64'hAA, 4'd0); wb(1, 5'd7, 64'hBB, 4'd0); rd_addr = {5'd7, 5'd7};
        #2; check("collide bypass0", rd_data[0], 64'hBB); check("collide bypass1", rd_data[1], 64'hBB);
        cyc(); idle();
        #2; check("collide stored", rd_data[0], 64'hBB);

        // WAW: only the youngest writer releases
        cyc(); iss(5'd9, 4'd1); rd_addr[0] = 5'd9;
        cyc(); iss(5'd9, 4'd2);
        #2; check("waw busy after first issue", 64'(rd_busy[0]), 64'h1);
        cyc(); idle(); wb(0, 5'd9, 64'h11, 4'd1);
        #2; check("waw stale wb busy", 64'(rd_busy[0]), 64'h1);
        cyc(); idle();
        #2; check("waw stale data", rd_data[0], 64'h11); check("waw count", 64'(busy_count), 64'h1);
        cyc(); wb(0, 5'd9, 64'h22, 4'd2);
        #2; check("waw release same cycle", 64'(rd_busy[0]), 64'h0); check("waw data", rd_data[0], 64'h22);
        cyc(); idle();
        #2; check("waw count after release", 64'(busy_count), 64'h0);

        // Issue beats same-cycle release, flush beats issue
        cyc(); iss(5'd4, 4'd5); rd_addr = {5'd6, 5'd4};
        cyc(); iss(5'd4, 4'd5); wb(0, 5'd4, 64'h44, 4'd5);
        #2; check("iss+rel bypass busy", 64'(rd_busy[0]), 64'h0);
        cyc(); idle();
        #2; check("iss+rel still busy", 64'(rd_busy[0]), 64'h1); check("iss+rel count", 64'(busy_count), 64'h1);
        cyc(); flush = 1'b1; iss(5'd6, 4'd1);
        cyc(); idle();
        #2; check("flush x4", 64'(rd_busy[0]), 64'h0); check("flush x6", 64'(rd_busy[1]), 64'h0);
        check("flush count", 64'(busy_count), 64'h0);

        // Async reset with issues outstanding
        cyc(); iss(5'd3, 4'd1);
        cyc(); iss(5'd8, 4'd2);
        cyc(); iss(5'd12, 4'd3);
        cyc(); idle(); rd_addr = {5'd7, 5'd3};
        #2; check("pre-reset count", 64'(busy_count), 64'h3); check("pre-reset x7", rd_data[1], 64'hBB);
        reset = 1'b0;
        #1; check("async x7", rd_data[1], 64'h0); check("async busy x3", 64'(rd_busy[0]), 64'h0);
        check("async count", 64'(busy_count), 64'h0);
        cyc(); cyc(); reset = 1'b1;
        cyc(); wb(0, 5'd3, 64'h55, 4'd0);
        #2; check("late wb bypass", rd_data[0], 64'h55); check("late wb busy", 64'(rd_busy[0]), 64'h0);
        cyc(); idle();
        #2; check("late wb stored", rd_data[0], 64'h55); check("late wb count", 64'(busy_count), 64'h0);

        // Mixed traffic, checked by the model only
        for (int k = 0; k < 60; k++) begin
            cyc(); idle();
            iss_valid = 1'($urandom_range(0, 1)); iss_addr = AW'($urandom_range(0, 7)); iss_tag = TW'($urandom);
            for (int i = 0; i < NWR; i++) begin
                wb_valid[i] = 1'($urandom_range(0, 1)); wb_addr[i] = AW'($urandom_range(0, 7));
                wb_data[i] = {$urandom, $urandom}; wb_tag[i] = TW'($urandom_range(0, 3));
            end
            flush = ($urandom_range(0, 15) == 0);
            for (int j = 0; j < NRD; j++) rd_addr[j] = AW'($urandom_range(0, 7));
        end
        cyc(); idle();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
